data_mem_responder: RTL and testbench

// - Memory-side responder for CPU data-memory load/store requests: valid/ready request and response channels.
// - Sits between the CPU datapath (ALU-out address, B-register store data) and a 64-bit word RAM.
// - Adds programmable wait states and byte-enable writes; one transaction in flight.

---
 rtl/data_mem_responder.sv | 133 +++++++++++++
 tb/tb_data_mem_responder.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// data_mem_responder: memory-side responder for CPU data loads/stores.
// A 64-bit word RAM is accessed after WAIT_CYCLES wait states. Stores honour
// per-byte enables. Only one transaction is in flight at a time.
// Optional feature macro: MEM_RESP_ERR_EN. When it is defined, misaligned or
// out-of-range requests return resp_err=1 and do not touch the RAM. When it is
// undefined, the low three address bits are ignored and the word index wraps.
//
// Handshake semantics (both channels): a transfer happens on a rising clock
// edge where valid and ready are both high. The request is accepted only in
// IDLE, when req_ready=1. The requester holds its request until it is accepted.
// resp_valid stays high, with resp_rdata and resp_err stable, until the edge
// on which resp_ready is also high.
module data_mem_responder #(
  parameter int ADDR_W      = 32,
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [63:0]       req_wdata,
  input  logic [7:0]        req_be,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [63:0]       resp_rdata,
  output logic              resp_err,
  output logic              busy,
  output logic [1:0]        o_dbg_state
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t            r_state;
  logic [3:0]        r_cnt;
  logic              r_wr;
  logic [ADDR_W-1:0] r_addr;
  logic [63:0]       r_wdata;
  logic [7:0]        r_be;
  logic              r_resp_valid;
  logic [63:0]       r_rdata;
  logic              r_err;
  logic [63:0]       r_mem [DEPTH_WORDS];

  logic [IDX_W-1:0]  w_idx;
  logic              w_err;
  logic              w_commit;

  assign w_idx = r_addr[3 +: IDX_W];

`ifdef MEM_RESP_ERR_EN
  // The RAM size is a power of two. So the index is out of range exactly when
  // any address bit above it is set.
  assign w_err = (r_addr[2:0] != 3'd0) || ((r_addr >> (IDX_W + 3)) != '0);
`else
  logic w_unused_addr;
  assign w_err         = 1'b0;
  assign w_unused_addr = ^{r_addr[2:0], r_addr[ADDR_W-1:IDX_W+3]};
`endif

  // The access commits on the last WAIT edge. A simultaneous reset cancels it.
  assign w_commit = (r_state == S_WAIT) && (r_cnt == 4'd0) && !reset;

  // Request/response FSM: capture the request, count wait states, then hold the response
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_cnt        <= 4'd0;
      r_wr         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_be         <= '0;
      r_resp_valid <= 1'b0;
      r_rdata      <= '0;
      r_err        <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_wr    <= req_wr;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
            r_be    <= req_be;
            r_cnt   <= 4'(WAIT_CYCLES);
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
          end else begin
            r_state      <= S_RESP;
            r_resp_valid <= 1'b1;
            r_err        <= w_err;
            r_rdata      <= (!r_wr && !w_err) ? r_mem[w_idx] : 64'd0;
          end
        end
        S_RESP: begin
          if (resp_ready) begin
            r_state      <= S_IDLE;
            r_resp_valid <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // RAM store port: on the commit edge, write only the enabled bytes
  always_ff @(posedge clock) begin
    if (w_commit && r_wr && !w_err) begin
      for (int i = 0; i < 8; i++) begin
        if (r_be[i]) r_mem[w_idx][8*i +: 8] <= r_wdata[8*i +: 8];
      end
    end
  end

  assign req_ready   = (r_state == S_IDLE);
  assign busy        = (r_state != S_IDLE);
  assign resp_valid  = r_resp_valid;
  assign resp_rdata  = r_rdata;
  assign resp_err    = r_err;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: directed and random load/store traffic. The results
// are compared against a word-array reference model of the memory.
module tb_data_mem_responder;

  localparam int ADDR_W      = 32;
  localparam int DEPTH       = 256;
  localparam int WAIT_CYCLES = 2;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_wr = 1'b0;
  logic [31:0] req_addr = '0;
  logic [63:0] req_wdata = '0;
  logic [7:0]  req_be = '0;
  logic        resp_ready = 1'b0;
  logic        req_ready;
  logic        resp_valid;
  logic [63:0] resp_rdata;
  logic        resp_err;
  logic        busy;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  logic [63:0] model_mem [DEPTH];
  logic [63:0] exp_q [$];

  data_mem_responder #(
    .ADDR_W(ADDR_W), .DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WAIT_CYCLES)
  ) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .busy(busy), .o_dbg_state(dbg_state)
  );

  // clock/reset
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // reference model
  function automatic bit model_err(input logic [31:0] a);
`ifdef MEM_RESP_ERR_EN
    return (a % 8 != 0) || (a >= 32'(DEPTH * 8));
`else
    return (a == 32'hFFFF_FFFF) && (a != 32'hFFFF_FFFF);
`endif
  endfunction

  function automatic int model_idx(input logic [31:0] a);
    return int'((a / 8) % DEPTH);
  endfunction

  function automatic logic [63:0] be_mask(input logic [7:0] be);
    logic [63:0] m;
    m = '0;
    for (int i = 0; i < 8; i++) if (be[i]) m = m | (64'hFF << (8 * i));
    return m;
  endfunction

  task automatic apply_reset();
    reset = 1'b1;
    req_valid = 1'b0;
    resp_ready = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    check("rst_req_ready", 64'(req_ready), 64'd1);
    check("rst_resp_valid", 64'(resp_valid), 64'd0);
    check("rst_resp_rdata", resp_rdata, 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_resp_err", 64'(resp_err), 64'd0);
  endtask

  // driver: one complete transaction. Called #1 after a rising edge.
  task automatic do_txn(input logic wr, input logic [31:0] addr, input logic [63:0] wdata,
                        input logic [7:0] be, input int hold, input bit early,
                        output logic [63:0] rdata_o, output logic err_o);
    int n;
    logic [63:0] exp_d;
    logic [63:0] m;
    bit exp_e;
    exp_e = model_err(addr);
    if (wr || exp_e) exp_d = 64'd0;
    else exp_d = model_mem[model_idx(addr)];
    if (wr && !exp_e) begin
      m = be_mask(be);
      model_mem[model_idx(addr)] = (model_mem[model_idx(addr)] & ~m) | (wdata & m);
    end
    exp_q.push_back(exp_d);

    req_valid = 1'b1; req_wr = wr; req_addr = addr; req_wdata = wdata; req_be = be;
    resp_ready = early;
    n = 0;
    while (req_ready !== 1'b1 && n < 20) begin
      @(posedge clock); #1; n++;
    end
    check("req_ready_timeout", 64'(n >= 20), 64'd0);
    @(posedge clock); #1;
    check("busy_after_accept", 64'(busy), 64'd1);
    check("ready_after_accept", 64'(req_ready), 64'd0);
    // Change the request inputs after the accept. The captured request must still be used.
    req_valid = 1'b0;
    req_wr = 1'($urandom);
    req_addr = $urandom;
    req_wdata = {$urandom, $urandom};
    req_be = 8'($urandom);
    n = 0;
    while (resp_valid !== 1'b1 && n < 40) begin
      @(posedge clock); #1; n++;
    end
    check("latency", 64'(n), 64'(WAIT_CYCLES + 1));
    exp_d = exp_q.pop_front();
    rdata_o = resp_rdata;
    err_o = resp_err;
    check("rdata", resp_rdata, exp_d);
    check("err", 64'(resp_err), 64'(exp_e));
    if (!early) begin
      for (int k = 0; k < hold; k++) begin
        req_valid = 1'b1;
        req_addr = $urandom;
        req_wr = 1'($urandom);
        @(posedge clock); #1;
        check("hold_valid", 64'(resp_valid), 64'd1);
        check("hold_rdata", resp_rdata, exp_d);
        check("hold_req_ready", 64'(req_ready), 64'd0);
      end
      req_valid = 1'b0;
      resp_ready = 1'b1;
    end
    @(posedge clock); #1;
    check("resp_cleared", 64'(resp_valid), 64'd0);
    check("idle_req_ready", 64'(req_ready), 64'd1);
    check("idle_busy", 64'(busy), 64'd0);
    resp_ready = 1'b0;
  endtask

  // A store that is cut short by reset on its first WAIT cycle
  task automatic abort_store(input logic [31:0] addr, input logic [63:0] wdata);
    req_valid = 1'b1; req_wr = 1'b1; req_addr = addr; req_wdata = wdata; req_be = 8'hFF;
    resp_ready = 1'b0;
    @(posedge clock); #1;
    check("abort_accepted", 64'(busy), 64'd1);
    req_valid = 1'b0;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_resp_valid", 64'(resp_valid), 64'd0);
    check("abort_req_ready", 64'(req_ready), 64'd1);
  endtask

  initial begin
    logic [63:0] r;
    logic e;
    logic [31:0] a;
    int w;

    apply_reset();

    // Full store followed by a load
    do_txn(1'b1, 32'h10, 64'h1122334455667788, 8'hFF, 0, 1'b1, r, e);
    do_txn(1'b0, 32'h10, 64'd0, 8'h00, 0, 1'b1, r, e);
    check("full_store_load", r, 64'h1122334455667788);

    // Partial store; the load response is held for five cycles
    do_txn(1'b1, 32'h10, 64'hAAAAAAAABBBBBBBB, 8'h0F, 0, 1'b0, r, e);
    do_txn(1'b0, 32'h10, 64'd0, 8'h00, 5, 1'b0, r, e);
    check("partial_store_load", r, 64'h11223344BBBBBBBB);

    // A store with no bytes enabled must leave the word unchanged
    do_txn(1'b1, 32'h10, 64'hFFFFFFFFFFFFFFFF, 8'h00, 1, 1'b0, r, e);
    check("be0_store_rdata", r, 64'd0);
    do_txn(1'b0, 32'h10, 64'd0, 8'h00, 0, 1'b1, r, e);
    check("be0_store_load", r, 64'h11223344BBBBBBBB);

    // Reset during WAIT abandons the store
    do_txn(1'b1, 32'h18, 64'h0123456789ABCDEF, 8'hFF, 0, 1'b1, r, e);
    abort_store(32'h18, 64'hDEAD);
    do_txn(1'b0, 32'h18, 64'd0, 8'h00, 0, 1'b1, r, e);
    check("abort_prev_contents", r, 64'h0123456789ABCDEF);

    // Address boundary cases
    do_txn(1'b1, 32'h0, 64'hCAFEF00D12345678, 8'hFF, 0, 1'b1, r, e);
`ifdef MEM_RESP_ERR_EN
    do_txn(1'b0, 32'h13, 64'd0, 8'h00, 0, 1'b1, r, e);
    check("misaligned_err", 64'(e), 64'd1);
    check("misaligned_rdata", r, 64'd0);
    do_txn(1'b1, 32'h800, 64'h0BADBEEF0BADBEEF, 8'hFF, 0, 1'b1, r, e);
    check("range_err", 64'(e), 64'd1);
    do_txn(1'b0, 32'h0, 64'd0, 8'h00, 0, 1'b1, r, e);
    check("range_word0_kept", r, 64'hCAFEF00D12345678);
`else
    do_txn(1'b0, 32'h13, 64'd0, 8'h00, 0, 1'b1, r, e);
    check("misaligned_word2", r, 64'h11223344BBBBBBBB);
    do_txn(1'b1, 32'h800, 64'h0BADBEEF0BADBEEF, 8'hFF, 0, 1'b1, r, e);
    do_txn(1'b0, 32'h0, 64'd0, 8'h00, 0, 1'b1, r, e);
    check("wrap_word0", r, 64'h0BADBEEF0BADBEEF);
`endif

    // Fill words 0..31 so that every later load has a known value
    for (int i = 0; i < 32; i++) begin
      do_txn(1'b1, 32'(i * 8), {$urandom, $urandom}, 8'hFF, 0, 1'b1, r, e);
    end

    // Random traffic: aligned, misaligned and aliased addresses
    for (int t = 0; t < 150; t++) begin
      w = $urandom_range(0, 31);
      a = 32'(w * 8);
      case ($urandom_range(0, 3))
        0: a = a + 32'($urandom_range(1, 7));
        1: a = a + 32'(DEPTH * 8 * $urandom_range(1, 100));
        default: ;
      endcase
      do_txn(1'($urandom), a, {$urandom, $urandom}, 8'($urandom),
             $urandom_range(0, 3), 1'($urandom), r, e);
    end

    check("exp_q_empty", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  // Overall time limit for the run
  initial begin
    #2000000;
    $display("FAIL global_timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
